// File: rtl/mpu_ctrl.sv
// MPU sequencing controller: fetch/exec/commit FSM with host-memory read and user IRQ.
// Optional MPU_CTRL_HM_SYNC_EN: 2-flop synchronizer on hm_ack.
module mpu_ctrl #(
   parameter int AW         = 16,
   parameter int IW         = 48,
   parameter int DW         = 64,
   parameter int HM_TIMEOUT = 1023,
   parameter int RESET_IP   = 0
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          en,
   output logic [AW-1:0] i_addr,
   input  logic [IW-1:0] i_data,
   output logic [IW-1:0] insn,
   output logic          insn_valid,
   input  logic [AW-1:0] ex_isize,
   input  logic          ex_load,
   input  logic [AW-1:0] ex_target,
   input  logic          ex_we,
   input  logic          ex_hm_req,
   input  logic [DW-1:0] ex_hm_addr,
   input  logic          ex_irq_req,
   input  logic [DW-1:0] ex_irq_data,
   input  logic          ex_error,
   output logic          we,
   output logic [DW-1:0] hm_addr,
   output logic          hm_start,
   input  logic          hm_ack,
   input  logic [DW-1:0] hm_data,
   output logic [DW-1:0] hm_rdata,
   output logic          hm_valid,
   output logic          user_irq,
   output logic [DW-1:0] user_data,
   input  logic          user_ack,
   output logic          error,
   output logic [1:0]    err_code,
   output logic          busy
);

   localparam int TW = $clog2(HM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HM_REQ,
      S_HM_REL,
      S_IRQ_WAIT,
      S_HALT
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] ip;
   logic [AW-1:0] ip_next;
   logic [AW-1:0] isize_q;
   logic [AW-1:0] target_q;
   logic          load_q;
   logic          we_q;
   logic [DW-1:0] hm_addr_q;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] udata_q;
   logic          err_q;
   logic [1:0]    code_q;
   logic [TW-1:0] tcnt;
   logic          t_out;
   logic          ack_s;

   logic          commit;
   logic          we_c;
   logic          hmv_c;
   logic          capture;
   logic          go_halt;
   logic [1:0]    halt_code;

   logic [AW-1:0] sel_size;
   logic [AW-1:0] sel_tgt;
   logic          sel_load;

`ifdef MPU_CTRL_HM_SYNC_EN
   logic [1:0] ack_sync;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[0], hm_ack};
      end
   end

   assign ack_s = ack_sync[1];
`else
   assign ack_s = hm_ack;
`endif

   // EXEC commits straight from the decoder; deferred commits use the held copy
   assign sel_load = (state == S_EXEC) ? ex_load   : load_q;
   assign sel_tgt  = (state == S_EXEC) ? ex_target : target_q;
   assign sel_size = (state == S_EXEC) ? ex_isize  : isize_q;
   assign ip_next  = sel_load ? sel_tgt : ip + sel_size;

   assign t_out = (tcnt == TW'(HM_TIMEOUT - 1));

   always_comb begin
      state_n   = state;
      commit    = 1'b0;
      we_c      = 1'b0;
      hmv_c     = 1'b0;
      capture   = 1'b0;
      go_halt   = 1'b0;
      halt_code = 2'b00;
      unique case (state)
         S_IDLE: begin
            if (en) state_n = S_FETCH;
         end
         S_FETCH: begin
            state_n = en ? S_EXEC : S_IDLE;
         end
         S_EXEC: begin
            if (ex_error) begin
               go_halt   = 1'b1;
               halt_code = 2'b01;
            end else if (ex_hm_req && ex_irq_req) begin
               go_halt   = 1'b1;
               halt_code = 2'b11;
            end else if (ex_hm_req) begin
               state_n = S_HM_REQ;
            end else if (ex_irq_req) begin
               state_n = S_IRQ_WAIT;
            end else begin
               commit  = 1'b1;
               we_c    = ex_we;
               state_n = S_FETCH;
            end
         end
         S_HM_REQ: begin
            if (t_out) begin
               go_halt   = 1'b1;
               halt_code = 2'b10;
            end else if (ack_s) begin
               capture = 1'b1;
               state_n = S_HM_REL;
            end
         end
         S_HM_REL: begin
            if (!ack_s) begin
               commit  = 1'b1;
               we_c    = we_q;
               hmv_c   = 1'b1;
               state_n = S_FETCH;
            end else if (t_out) begin
               go_halt   = 1'b1;
               halt_code = 2'b10;
            end
         end
         S_IRQ_WAIT: begin
            if (user_ack) begin
               commit  = 1'b1;
               state_n = S_FETCH;
            end
         end
         S_HALT: begin
            state_n = S_HALT;
         end
         default: begin
            state_n = S_HALT;
         end
      endcase
      if (go_halt) state_n = S_HALT;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= S_IDLE;
         ip        <= AW'(RESET_IP);
         isize_q   <= '0;
         target_q  <= '0;
         load_q    <= 1'b0;
         we_q      <= 1'b0;
         hm_addr_q <= '0;
         rdata_q   <= '0;
         udata_q   <= '0;
         err_q     <= 1'b0;
         code_q    <= 2'b00;
         tcnt      <= '0;
      end else begin
         state <= state_n;
         if (commit) ip <= ip_next;
         if (state == S_EXEC) begin
            isize_q  <= ex_isize;
            load_q   <= ex_load;
            target_q <= ex_target;
            we_q     <= ex_we;
         end
         if (state == S_EXEC && state_n == S_HM_REQ) begin
            hm_addr_q <= ex_hm_addr;
            tcnt      <= '0;
         end else if (state == S_HM_REQ || state == S_HM_REL) begin
            tcnt <= tcnt + TW'(1);
         end
         if (state == S_EXEC && state_n == S_IRQ_WAIT) begin
            udata_q <= ex_irq_data;
         end
         if (capture) rdata_q <= hm_data;
         if (go_halt) begin
            err_q  <= 1'b1;
            code_q <= halt_code;
         end
      end
   end

   assign i_addr     = ip;
   assign insn       = i_data;
   assign insn_valid = (state == S_EXEC) || (state == S_HM_REQ) ||
                       (state == S_HM_REL) || (state == S_IRQ_WAIT);
   assign we         = we_c;
   assign hm_addr    = hm_addr_q;
   assign hm_start   = (state == S_HM_REQ);
   assign hm_rdata   = rdata_q;
   assign hm_valid   = hmv_c;
   assign user_irq   = (state == S_IRQ_WAIT);
   assign user_data  = udata_q;
   assign error      = err_q;
   assign err_code   = code_q;
   assign busy       = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: doc/mpu_ctrl.md
Name: mpu_ctrl

Overview:
- Parametrised sequencing controller for the MPU.
- Replaces the free-running instruction counter with a state machine that fetches from synchronous instruction memory and presents each instruction to the decoder/execution path.
- Commits execution results (IP update, register write enable) and runs multi-cycle side operations: a four-phase host-memory read with timeout and a user IRQ with acknowledge.
- Errors latch and halt the unit.

Parameters:
AW, 16, instruction address width
IW, 48, instruction word width
DW, 64, host address, host data and user data width
HM_TIMEOUT, 1023, maximum cycles spent in a host-memory transaction before timeout error
RESET_IP, 0, instruction pointer value after reset

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
en  in  1  run enable
i_addr  out  AW  instruction memory address (1-cycle read latency)
i_data  in  IW  instruction memory data
insn  out  IW  instruction presented to decoder (pass-through of i_data)
insn_valid  out  1  high in EXEC, HM_REQ, HM_REL and IRQ_WAIT
ex_isize  in  AW  size of current instruction
ex_load  in  1  branch: load ex_target into IP
ex_target  in  AW  branch target
ex_we  in  1  execution requests register write
ex_hm_req  in  1  instruction is a host-memory read
ex_hm_addr  in  DW  host address
ex_irq_req  in  1  instruction raises user IRQ
ex_irq_data  in  DW  IRQ payload
ex_error  in  1  decode/execution error
we  out  1  gated register write enable
hm_addr  out  DW  host address, held for whole transaction
hm_start  out  1  four-phase request
hm_ack  in  1  four-phase acknowledge (other clock domain permitted)
hm_data  in  DW  host read data, valid while hm_ack high
hm_rdata  out  DW  captured host data
hm_valid  out  1  one-cycle pulse, hm_rdata valid
user_irq  out  1  IRQ level
user_data  out  DW  IRQ payload, held while user_irq high
user_ack  in  1  IRQ acknowledge
error  out  1  sticky error
err_code  out  2  01 execution error, 10 host timeout, 11 hm_req and irq_req together
busy  out  1  state is not IDLE and not HALT

Behaviour:
- Reset values:
  - state IDLE, ip=RESET_IP, i_addr=RESET_IP.
  - All outputs 0, except insn, which follows i_data.
- i_addr=ip at all times; ip changes only at commit.
- IDLE: en=1 -> FETCH.
- FETCH: 1 cycle; en=0 -> IDLE, else -> EXEC. Minimum 2 cycles per plain instruction.
- EXEC: single cycle in which the ex_* inputs are sampled.
  - ex_error=1 -> HALT, err_code=01.
  - ex_hm_req=1 and ex_irq_req=1 together -> HALT, err_code=11.
  - ex_hm_req=1 -> latch hm_addr, go HM_REQ.
  - ex_irq_req=1 -> latch user_data, go IRQ_WAIT.
  - Otherwise commit: we=ex_we, ip updated, -> FETCH.
- Commit rule: ip = ex_load ? ex_target : ip+ex_isize, modulo 2^AW. Wrap-around is silent.
- ex_load and ex_isize are sampled in EXEC and held internally for deferred commits.
- HM_REQ: hm_start=1 until ack_s=1 (ack_s is hm_ack, or its synchronised version). On ack_s=1:
  - capture hm_data into hm_rdata;
  - hm_start=0;
  - -> HM_REL.
- HM_REL: on ack_s=0, commit:
  - hm_valid=1 and we=ex_we for 1 cycle;
  - -> FETCH.
- Timeout counter:
  - cleared on entering HM_REQ, counts every cycle in HM_REQ/HM_REL;
  - reaching HM_TIMEOUT -> HALT, err_code=10, hm_start=0, no commit.
- IRQ_WAIT: user_irq=1 until user_ack=1. Then user_irq=0, commit without we, -> FETCH.
  - user_ack already high on entry completes after 1 cycle.
- HALT: error=1 sticky; outputs idle; leaves only on reset.
- en=0 is honoured only in FETCH; in-flight HM/IRQ operations complete.
- Asynchronous reset mid-transaction drops hm_start/user_irq immediately; ip returns to RESET_IP.

Optional Feature:
- Macro MPU_CTRL_HM_SYNC_EN.
- Defined: hm_ack passes through a 2-flop synchronizer on sys_clk before use (ack_s). This adds 2 cycles to each edge detection.
- Undefined: ack_s=hm_ack directly; host must be synchronous to sys_clk.

Test Plan:
- Reset, en=1, each instruction ex_isize=6, no load: i_addr sequence 0,6,12 with one commit every 2 cycles; we mirrors ex_we only in EXEC.
- Branch: ex_load=1, ex_target=0x0100 at ip=6 -> next i_addr=0x0100; ip=0xFFFC+ex_isize 6 -> i_addr=0x0002.
- Host read: ex_hm_addr=0x1000, hm_ack raised 5 cycles after hm_start with hm_data=0xDEADBEEF -> hm_start falls, then after hm_ack falls hm_valid pulses with hm_rdata=0xDEADBEEF and ip advances (HM_SYNC_EN adds 2 cycles per edge).
- Timeout: HM_TIMEOUT=15, hm_ack never raised -> after 15 cycles error=1, err_code=10, hm_start=0, busy=0, ip unchanged.
- IRQ: ex_irq_data=0x42, user_ack after 3 cycles -> user_irq high 3 cycles with user_data=0x42, then ip advances; then ex_hm_req=ex_irq_req=1 -> error, err_code=11.
- en dropped during HM_REQ -> transaction completes, then IDLE after next FETCH; reset asserted mid HM_REQ -> hm_start=0 immediately, i_addr=RESET_IP.
